// File: rtl/aes_out_serializer_if.sv
// Block-in / byte-out handshake bundle for the AES output serializer.
// master = AES core plus byte sink side, slave = serializer.
interface aes_out_serializer_if #(
    parameter int NBYTES = 16
);
    logic [8*NBYTES-1:0] blk_in;
    logic                blk_valid;
    logic                blk_ready;
    logic [7:0]          out;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                busy;

    modport master (
        output blk_in, blk_valid, out_ready,
        input  blk_ready, out, out_valid, out_last, busy
    );

    modport slave (
        input  blk_in, blk_valid, out_ready,
        output blk_ready, out, out_valid, out_last, busy
    );
endinterface

// File: rtl/aes_out_serializer.sv
// Serializes one AES block into bytes with valid/ready handshaking, MSB first.
// Define AES_SER_LSB_FIRST_EN to emit blk_in[7:0] first instead.
module aes_out_serializer #(
    parameter int NBYTES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_out_serializer_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [W-1:0]    sreg;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.blk_valid) begin
                        sreg  <= bus.blk_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.out_ready) begin
`ifdef AES_SER_LSB_FIRST_EN
                        sreg <= sreg >> 8;
`else
                        sreg <= sreg << 8;
`endif
                        // Counter parks at 0 on the final byte instead of wrapping.
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wire in_shift = (state == SHIFT);

    assign bus.blk_ready = ~in_shift;
    assign bus.out_valid = in_shift;
    assign bus.busy      = in_shift;
    assign bus.out_last  = in_shift && (cnt == LAST);
`ifdef AES_SER_LSB_FIRST_EN
    assign bus.out       = in_shift ? sreg[7:0] : 8'h00;
`else
    assign bus.out       = in_shift ? sreg[W-1 -: 8] : 8'h00;
`endif
endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer: basic, backpressure, ignored input,
// back-to-back and mid-block reset. Inputs driven and outputs sampled on negedge.
module tb_aes_out_serializer;
    localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B2 = 128'hffeeddccbbaa99887766554433221100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    aes_out_serializer_if #(.NBYTES(16)) bus ();

    aes_out_serializer #(.NBYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // B1 emits 00,11,..,ff in MSB-first order; B2 the reverse. LSB-first swaps them.
    function automatic logic [7:0] exp_byte(input bit rev, input int i);
        bit r;
        r = rev;
`ifdef AES_SER_LSB_FIRST_EN
        r = ~r;
`endif
        return r ? 8'((15 - i) * 8'h11) : 8'(i * 8'h11);
    endfunction

    // Called on the negedge right after capture. Checks n presented bytes,
    // optionally stalling at byte stall_at, and the IDLE cycle after a full block.
    task automatic emit(input bit rev, input int n, input int stall_at, input int stall_n,
                        input bit keep_valid);
        if (!keep_valid) bus.blk_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_out",   {24'h0, bus.out}, {24'h0, exp_byte(rev, i)});
                    chk("stall_valid", {31'h0, bus.out_valid}, 32'd1);
                    chk("stall_last",  {31'h0, bus.out_last}, 32'd0);
                end
                bus.out_ready = 1'b1;
            end
            chk("out",       {24'h0, bus.out}, {24'h0, exp_byte(rev, i)});
            chk("out_valid", {31'h0, bus.out_valid}, 32'd1);
            chk("out_last",  {31'h0, bus.out_last}, {31'h0, (i == 15)});
            chk("blk_ready", {31'h0, bus.blk_ready}, 32'd0);
            chk("busy",      {31'h0, bus.busy}, 32'd1);
            if (i < n - 1 || n == 16) @(negedge clk);
        end
        if (n == 16) begin
            chk("idle_ready", {31'h0, bus.blk_ready}, 32'd1);
            chk("idle_valid", {31'h0, bus.out_valid}, 32'd0);
            chk("idle_out",   {24'h0, bus.out}, 32'd0);
            chk("idle_last",  {31'h0, bus.out_last}, 32'd0);
        end
    endtask

    initial begin
        bus.blk_in    = '0;
        bus.blk_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("rst_out",   {24'h0, bus.out}, 32'd0);
        chk("rst_busy",  {31'h0, bus.busy}, 32'd0);
        chk("rst_last",  {31'h0, bus.out_last}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, bus.blk_ready}, 32'd1);

        // Idle with out_ready high must not emit anything.
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("idle_ign", {31'h0, bus.out_valid}, 32'd0);

        // Basic block.
        bus.blk_in = B1; bus.blk_valid = 1'b1;
        @(negedge clk);
        emit(1'b0, 16, -1, 0, 1'b0);

        // Backpressure: 3 stalled cycles on byte 5.
        bus.blk_in = B1; bus.blk_valid = 1'b1;
        @(negedge clk);
        emit(1'b0, 16, 5, 3, 1'b0);

        // New block offered during SHIFT is ignored, then taken right after IDLE.
        bus.blk_in = B1; bus.blk_valid = 1'b1;
        @(negedge clk);
        bus.blk_in = B2;
        emit(1'b0, 16, -1, 0, 1'b1);
        @(negedge clk);
        emit(1'b1, 16, -1, 0, 1'b0);

        // Mid-block reset after 7 bytes transferred.
        bus.blk_in = B1; bus.blk_valid = 1'b1;
        @(negedge clk);
        emit(1'b0, 8, -1, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mrst_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("mrst_out",   {24'h0, bus.out}, 32'd0);
        chk("mrst_busy",  {31'h0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready", {31'h0, bus.blk_ready}, 32'd1);
        bus.blk_in = B2; bus.blk_valid = 1'b1;
        @(negedge clk);
        emit(1'b1, 16, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 Parameter: NBYTES, default 16, number of bytes per block; the block width is 8*NBYTES bits.
REQ-002 Port: clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Port: rst, input, 1, reset; asynchronous, active-high.
REQ-004 Port: blk_in, input, 8*NBYTES, ciphertext block from the AES core.
REQ-005 Port: blk_valid, input, 1, blk_in holds a valid block.
REQ-006 Port: blk_ready, output, 1, serializer can accept a block.
REQ-007 Port: out, output, 8, current output byte.
REQ-008 Port: out_valid, output, 1, out holds a valid byte.
REQ-009 Port: out_ready, input, 1, sink accepts the byte this cycle.
REQ-010 Port: out_last, output, 1, the current byte is the final byte of the block.
REQ-011 Port: busy, output, 1, a block is held and not yet fully emitted.

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 In IDLE, blk_ready SHALL be 1; in SHIFT, it SHALL be 0.
REQ-014 On a clk edge with blk_valid=1 and blk_ready=1, the block SHALL:
- capture blk_in into a 8*NBYTES-bit shift register,
- clear the byte counter to 0,
- enter SHIFT.
REQ-015 out_valid SHALL be 1 exactly while in SHIFT, starting the cycle after capture (latency 1 cycle).
REQ-016 out SHALL present:
- the most-significant byte of the shift register (blk_in[8*NBYTES-1 : 8*NBYTES-8] first),
- unless the AES_SER_LSB_FIRST_EN macro selects LSB-first order (REQ-026).
REQ-017 A byte SHALL be transferred only on an edge with out_valid=1 and out_ready=1. On a transfer:
- the shift register SHALL shift by 8 bits toward the output end,
- the counter SHALL increment by 1.
REQ-018 While out_valid=1 and out_ready=0, out, out_last and the state SHALL hold stable.
REQ-019 out_last SHALL be 1 only while in SHIFT with counter = NBYTES-1.
REQ-020 On the transfer with out_last=1, the block SHALL return to IDLE, and blk_ready SHALL be 1 the next cycle. A new block is accepted no earlier than one cycle after the final byte.
REQ-021 The counter SHALL be ceil(log2(NBYTES)) bits wide and SHALL never wrap within a block.
REQ-022 busy SHALL equal (state == SHIFT).
REQ-023 In SHIFT, blk_valid SHALL be ignored and the block is not captured. In IDLE, out_ready SHALL be ignored.
REQ-024 When in IDLE, out SHALL be 8'h00.

Reset
REQ-025 Asserting rst at any time, including mid-block, SHALL asynchronously force all of the following, and any partially emitted block SHALL be discarded:
- state = IDLE, counter = 0, shift register = 0,
- out = 8'h00, out_valid = 0, out_last = 0, busy = 0,
- blk_ready = 1 after rst deasserts.

Configuration
REQ-026 Macro AES_SER_LSB_FIRST_EN:
- defined: bytes are emitted least-significant first (blk_in[7:0] first) and the register shifts the opposite way;
- undefined: MSB-first per REQ-016.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-027 Basic block: blk_in=128'h00112233445566778899aabbccddeeff, out_ready held 1 -> out emits 00,11,...,ff over 16 consecutive cycles starting 1 cycle after capture; out_last=1 only with ff; blk_ready=1 the cycle after.
REQ-028 Backpressure: same block, out_ready=0 for 3 cycles at byte 5 -> out holds 8'h55 with out_valid=1 for those cycles; the sequence resumes unchanged and still totals 16 bytes.
REQ-029 Ignored input: blk_valid=1 with new data during SHIFT -> no capture; the original 16 bytes are emitted intact; the new block is captured only after return to IDLE.
REQ-030 Mid-block reset: assert rst after byte 7 -> out_valid=0, out=8'h00, busy=0 immediately; after release, a fresh block is emitted from byte 0.
REQ-031 With AES_SER_LSB_FIRST_EN defined, block from REQ-027 -> out emits ff,ee,...,00, with out_last on 00.
REQ-032 Back-to-back: blk_valid held 1 with two blocks -> 16 bytes, one IDLE cycle, then 16 bytes; no byte lost or duplicated.
